uart_bus_master: RTL and testbench

- UART-driven bus initiator for debug and program loading: decodes command frames from the receive byte stream and issues single-word MemRead/MemWrite accesses on the CPU data bus.
- Returns status and read data through the transmit byte interface.
- Sits between the uart_rx/uart_tx byte engines and the bus arbiter; it is the initiator side of the same bus that the memory-mapped UART peripheral answers as a responder.

---
 rtl/uart_bus_master.sv | 197 +++++++++++++++++++
 tb/tb_uart_bus_master.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_bus_master.sv
// uart_bus_master: UART-driven bus initiator for debug and program loading.
// Decodes write (8'h57 + addr[4] + data[4]) and read (8'h52 + addr[4]) frames
// from the uart_rx byte stream, issues one single-word MemWrite/MemRead on the
// CPU data bus, and returns ACK / NAK / 4 read-data bytes through uart_tx.
// Ports:
//   clk, reset (sync, active-low)
//   Rx_DV, Rx_Byte            : received byte strobe / data from uart_rx
//   Tx_DV, Tx_Byte            : transmit start strobe / data to uart_tx
//   Tx_Active, Tx_Done        : transmitter busy / byte-finished strobe
//   MemRead, MemWrite         : one-cycle bus strobes
//   Address, Write_data       : bus address / write data (held outside strobes)
//   Read_data                 : combinational read data from the responder
//   Busy                      : bus request to the arbiter, frame start to response end
module uart_bus_master #(
  parameter int unsigned TIMEOUT_CLKS = 1_000_000,
  parameter logic [7:0]  ACK_BYTE     = 8'h06,
  parameter logic [7:0]  NAK_BYTE     = 8'h15
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        Rx_DV,
  input  logic [7:0]  Rx_Byte,
  output logic        Tx_DV,
  output logic [7:0]  Tx_Byte,
  input  logic        Tx_Active,
  input  logic        Tx_Done,
  output logic        MemRead,
  output logic        MemWrite,
  output logic [31:0] Address,
  output logic [31:0] Write_data,
  input  logic [31:0] Read_data,
  output logic        Busy
);

  localparam logic [7:0] CMD_WR = 8'h57;
  localparam logic [7:0] CMD_RD = 8'h52;

  // Counter only needs to reach TIMEOUT_CLKS-1; the step past that fires the abort.
  localparam int unsigned     TMO_W    = (TIMEOUT_CLKS > 1) ? $clog2(TIMEOUT_CLKS) : 1;
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CLKS - 1);

  typedef enum logic [2:0] {
    IDLE, ADDR, DATA, BUS_WR, BUS_RD, TX_LOAD, TX_WAIT
  } state_t;

  state_t           state_q, state_d;
  logic             cmd_wr_q, cmd_wr_d;
  logic [1:0]       byte_cnt_q, byte_cnt_d;
  logic [TMO_W-1:0] tmo_q, tmo_d;
  logic [31:0]      resp_q, resp_d;
  logic [2:0]       resp_cnt_q, resp_cnt_d;
  logic             tx_dv_q, tx_dv_d;
  logic [7:0]       tx_byte_q, tx_byte_d;
  logic             mem_rd_q, mem_rd_d;
  logic             mem_wr_q, mem_wr_d;
  logic [31:0]      addr_q, addr_d;
  logic [31:0]      wdata_q, wdata_d;
  logic             busy_q, busy_d;

  always_comb begin
    state_d    = state_q;
    cmd_wr_d   = cmd_wr_q;
    byte_cnt_d = byte_cnt_q;
    tmo_d      = tmo_q;
    resp_d     = resp_q;
    resp_cnt_d = resp_cnt_q;
    tx_dv_d    = 1'b0;
    tx_byte_d  = tx_byte_q;
    mem_rd_d   = 1'b0;
    mem_wr_d   = 1'b0;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    busy_d     = busy_q;

    case (state_q)
      IDLE: begin
        if (Rx_DV) begin
          busy_d     = 1'b1;
          tmo_d      = '0;
          byte_cnt_d = '0;
          if (Rx_Byte == CMD_WR || Rx_Byte == CMD_RD) begin
            cmd_wr_d = (Rx_Byte == CMD_WR);
            state_d  = ADDR;
          end else begin
            resp_d     = {NAK_BYTE, 24'h0};
            resp_cnt_d = 3'd1;
            state_d    = TX_LOAD;
          end
        end
      end

      ADDR, DATA: begin
        if (Rx_DV) begin
          // A byte arriving on the timeout cycle still counts.
          tmo_d      = '0;
          byte_cnt_d = byte_cnt_q + 2'd1;
          if (state_q == ADDR) addr_d  = {addr_q[23:0], Rx_Byte};
          else                 wdata_d = {wdata_q[23:0], Rx_Byte};
          if (byte_cnt_q == 2'd3) begin
            // Strobes are registered, so raise them on entry to the bus state.
            if (state_q == ADDR && cmd_wr_q) begin
              state_d = DATA;
            end else if (state_q == ADDR) begin
              state_d  = BUS_RD;
              mem_rd_d = 1'b1;
            end else begin
              state_d  = BUS_WR;
              mem_wr_d = 1'b1;
            end
          end
        end else if (tmo_q == TMO_LAST) begin
          tmo_d   = '0;
          busy_d  = 1'b0;
          state_d = IDLE;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end

      BUS_WR: begin
        resp_d     = {ACK_BYTE, 24'h0};
        resp_cnt_d = 3'd1;
        state_d    = TX_LOAD;
      end

      BUS_RD: begin
        resp_d     = Read_data;
        resp_cnt_d = 3'd4;
        state_d    = TX_LOAD;
      end

      TX_LOAD: begin
        if (!Tx_Active) begin
          tx_byte_d = resp_q[31:24];
          resp_d    = {resp_q[23:0], 8'h00};
          tx_dv_d   = 1'b1;
          state_d   = TX_WAIT;
        end
      end

      TX_WAIT: begin
        if (Tx_Done) begin
          resp_cnt_d = resp_cnt_q - 3'd1;
          if (resp_cnt_q == 3'd1) begin
            busy_d  = 1'b0;
            state_d = IDLE;
          end else begin
            state_d = TX_LOAD;
          end
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= IDLE;
      cmd_wr_q   <= 1'b0;
      byte_cnt_q <= '0;
      tmo_q      <= '0;
      resp_q     <= '0;
      resp_cnt_q <= '0;
      tx_dv_q    <= 1'b0;
      tx_byte_q  <= '0;
      mem_rd_q   <= 1'b0;
      mem_wr_q   <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cmd_wr_q   <= cmd_wr_d;
      byte_cnt_q <= byte_cnt_d;
      tmo_q      <= tmo_d;
      resp_q     <= resp_d;
      resp_cnt_q <= resp_cnt_d;
      tx_dv_q    <= tx_dv_d;
      tx_byte_q  <= tx_byte_d;
      mem_rd_q   <= mem_rd_d;
      mem_wr_q   <= mem_wr_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      busy_q     <= busy_d;
    end
  end

  assign Tx_DV      = tx_dv_q;
  assign Tx_Byte    = tx_byte_q;
  assign MemRead    = mem_rd_q;
  assign MemWrite   = mem_wr_q;
  assign Address    = addr_q;
  assign Write_data = wdata_q;
  assign Busy       = busy_q;

endmodule

// File: tb/tb_uart_bus_master.sv
// tb_uart_bus_master: directed bench for uart_bus_master with a simple
// uart_tx stand-in (Tx_Active for a few cycles after each Tx_DV, then Tx_Done).
module tb_uart_bus_master;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        Rx_DV = 1'b0;
  logic [7:0]  Rx_Byte = '0;
  logic        Tx_DV;
  logic [7:0]  Tx_Byte;
  logic        Tx_Active;
  logic        Tx_Done = 1'b0;
  logic        MemRead;
  logic        MemWrite;
  logic [31:0] Address;
  logic [31:0] Write_data;
  logic [31:0] Read_data;
  logic        Busy;

  logic        tx_act = 1'b0;
  logic        tx_hold = 1'b0;
  logic [31:0] rd_val = '0;
  int          tx_cnt = 0;

  assign Tx_Active = tx_act | tx_hold;
  // Responder drives valid data only while addressed.
  assign Read_data = MemRead ? rd_val : 32'hFFFF_FFFF;

  uart_bus_master #(.TIMEOUT_CLKS(100)) dut (
    .clk(clk), .reset(reset),
    .Rx_DV(Rx_DV), .Rx_Byte(Rx_Byte),
    .Tx_DV(Tx_DV), .Tx_Byte(Tx_Byte), .Tx_Active(Tx_Active), .Tx_Done(Tx_Done),
    .MemRead(MemRead), .MemWrite(MemWrite),
    .Address(Address), .Write_data(Write_data), .Read_data(Read_data),
    .Busy(Busy)
  );

  always #5 clk = ~clk;

  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          last_rx_cyc = 0;
  int          strobe_cyc = 0;
  int          wr_cnt = 0;
  int          rd_cnt = 0;
  int          both_cnt = 0;
  int          overlap_cnt = 0;
  int          wr_lat = 0;
  int          rd_lat = 0;
  int          tx_lat = 0;
  logic [31:0] wr_addr = '0;
  logic [31:0] wr_data = '0;
  logic [31:0] rd_addr = '0;
  logic [7:0]  tx_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  // Monitor and transmitter model share one block so their ordering is fixed.
  always @(negedge clk) begin
    cyc++;
    if (Rx_DV) last_rx_cyc = cyc;
    if (MemWrite) begin
      wr_cnt++; wr_addr = Address; wr_data = Write_data;
      strobe_cyc = cyc; wr_lat = cyc - last_rx_cyc;
    end
    if (MemRead) begin
      rd_cnt++; rd_addr = Address;
      strobe_cyc = cyc; rd_lat = cyc - last_rx_cyc;
    end
    if (MemRead && MemWrite) both_cnt++;
    Tx_Done = 1'b0;
    if (Tx_DV) begin
      if (tx_q.size() == 0) tx_lat = cyc - strobe_cyc;
      if (Tx_Active) overlap_cnt++;
      tx_q.push_back(Tx_Byte);
      tx_cnt = 4;
      tx_act = 1'b1;
    end else if (tx_cnt != 0) begin
      tx_cnt--;
      if (tx_cnt == 0) begin
        tx_act  = 1'b0;
        Tx_Done = 1'b1;
      end
    end
  end

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(posedge clk); #1;
    Rx_DV = 1'b1; Rx_Byte = b;
    @(posedge clk); #1;
    Rx_DV = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] bytes[$]);
    foreach (bytes[i]) send_byte(bytes[i]);
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while (Busy && n < 2000) begin
      tick(1);
      n++;
    end
    check(tag, {31'b0, Busy}, 32'd0);
    tick(3);
  endtask

  task automatic clear_mon();
    wr_cnt = 0; rd_cnt = 0; tx_q.delete();
    wr_lat = 0; rd_lat = 0; tx_lat = 0;
  endtask

  initial begin
    logic [7:0] fr[$];

    // Reset state
    tick(3);
    check("rst_busy",  {31'b0, Busy}, 32'd0);
    check("rst_txdv",  {31'b0, Tx_DV}, 32'd0);
    check("rst_mem",   {30'b0, MemRead, MemWrite}, 32'd0);
    check("rst_addr",  Address, 32'd0);
    check("rst_wdata", Write_data, 32'd0);
    check("rst_txb",   {24'b0, Tx_Byte}, 32'd0);
    reset = 1'b1;
    tick(2);

    // Write frame
    clear_mon();
    send_byte(8'h57);
    check("wr_busy_set", {31'b0, Busy}, 32'd1);
    fr = '{8'h00, 8'h00, 8'h10, 8'h00, 8'hDE, 8'hAD, 8'hBE, 8'hEF};
    send_frame(fr);
    wait_idle("wr_idle");
    check("wr_cnt",  wr_cnt, 1);
    check("wr_rdcnt", rd_cnt, 0);
    check("wr_addr", wr_addr, 32'h0000_1000);
    check("wr_data", wr_data, 32'hDEAD_BEEF);
    check("wr_lat",  wr_lat, 1);
    check("wr_txlat", tx_lat, 2);
    check("wr_txn",  tx_q.size(), 1);
    if (tx_q.size() > 0) check("wr_ack", {24'b0, tx_q[0]}, 32'h06);

    // Read frame
    clear_mon();
    rd_val = 32'h1234_5678;
    fr = '{8'h52, 8'h40, 8'h00, 8'h00, 8'h1C};
    send_frame(fr);
    wait_idle("rd_idle");
    check("rd_cnt",   rd_cnt, 1);
    check("rd_wrcnt", wr_cnt, 0);
    check("rd_addr",  rd_addr, 32'h4000_001C);
    check("rd_lat",   rd_lat, 1);
    check("rd_txlat", tx_lat, 2);
    check("rd_txn",   tx_q.size(), 4);
    if (tx_q.size() == 4)
      check("rd_bytes", {tx_q[0], tx_q[1], tx_q[2], tx_q[3]}, 32'h1234_5678);

    // Unknown command
    clear_mon();
    send_byte(8'hAA);
    wait_idle("nak_idle");
    check("nak_mem", wr_cnt + rd_cnt, 0);
    check("nak_txn", tx_q.size(), 1);
    if (tx_q.size() > 0) check("nak_byte", {24'b0, tx_q[0]}, 32'h15);

    // Inter-byte timeout, then a normal read
    clear_mon();
    fr = '{8'h57, 8'h00, 8'h00};
    send_frame(fr);
    tick(50);
    check("tmo_busy_mid", {31'b0, Busy}, 32'd1);
    tick(70);
    check("tmo_busy", {31'b0, Busy}, 32'd0);
    check("tmo_mem",  wr_cnt + rd_cnt, 0);
    check("tmo_txn",  tx_q.size(), 0);
    rd_val = 32'hCAFE_F00D;
    fr = '{8'h52, 8'h00, 8'h00, 8'h00, 8'h04};
    send_frame(fr);
    wait_idle("tmo_rd_idle");
    check("tmo_rd_addr", rd_addr, 32'h0000_0004);
    check("tmo_rd_txn",  tx_q.size(), 4);
    if (tx_q.size() == 4)
      check("tmo_rd_bytes", {tx_q[0], tx_q[1], tx_q[2], tx_q[3]}, 32'hCAFE_F00D);

    // Transmitter held busy at TX_LOAD
    clear_mon();
    tx_hold = 1'b1;
    send_byte(8'h00);
    tick(50);
    check("hold_txn", tx_q.size(), 0);
    tx_hold = 1'b0;
    wait_idle("hold_idle");
    check("hold_txn_after", tx_q.size(), 1);
    if (tx_q.size() > 0) check("hold_byte", {24'b0, tx_q[0]}, 32'h15);

    // Reset mid-frame, then a full write
    clear_mon();
    fr = '{8'h57, 8'h00, 8'h00};
    send_frame(fr);
    reset = 1'b0;
    tick(1);
    reset = 1'b1;
    check("mrst_busy",  {31'b0, Busy}, 32'd0);
    check("mrst_outs",  {29'b0, Tx_DV, MemRead, MemWrite}, 32'd0);
    check("mrst_addr",  Address, 32'd0);
    check("mrst_wdata", Write_data, 32'd0);
    check("mrst_txb",   {24'b0, Tx_Byte}, 32'd0);
    fr = '{8'h57, 8'h00, 8'h00, 8'h20, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44};
    send_frame(fr);
    wait_idle("mrst_idle");
    check("mrst_wr_cnt",  wr_cnt, 1);
    check("mrst_wr_addr", wr_addr, 32'h0000_2000);
    check("mrst_wr_data", wr_data, 32'h1122_3344);
    check("mrst_txn",     tx_q.size(), 1);
    if (tx_q.size() > 0) check("mrst_ack", {24'b0, tx_q[0]}, 32'h06);

    check("never_both",   both_cnt, 0);
    check("tx_overlap",   overlap_cnt, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout got running expected finished");
    $fatal(1);
  end

endmodule
